ppi_bus_master: RTL and testbench

CPU-side bus initiator for the PPI_8255 peripheral. It turns single-cycle transaction requests from on-chip logic into correctly sequenced 8255 bus cycles on `cs`, `read`, `write`, `A_in` and `D`, with programmable setup, strobe and hold lengths. Read data is captured from `D` and returned with a completion pulse. It sits between an internal controller (sequencer, soft CPU, test harness) and the PPI_8255 instance.

---
 rtl/ppi_bus_master_if.sv | 24 ++
 rtl/ppi_bus_master.sv | 145 ++++++++++++++
 tb/tb_ppi_bus_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_bus_master_if.sv
// Request/response handshake and 8255 control lines between a controller and ppi_bus_master.
interface ppi_bus_master_if;
   logic       req;
   logic       we;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic       ready;
   logic       done;
   logic [7:0] rdata;
   logic       cs;
   logic       read;
   logic       write;
   logic [1:0] A_in;

   modport master (
      input  req, we, addr, wdata,
      output ready, done, rdata, cs, read, write, A_in
   );

   modport slave (
      output req, we, addr, wdata,
      input  ready, done, rdata, cs, read, write, A_in
   );
endinterface

// File: rtl/ppi_bus_master.sv
// Bus initiator for a PPI_8255: sequences cs/read/write/A_in/D with programmable
// setup, strobe and hold lengths and returns captured read data with a done pulse.
module ppi_bus_master #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   ppi_bus_master_if.master bus,
   inout  wire  [7:0]       D
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_cs;
   logic                r_read;
   logic                r_write;
   logic                r_oe;
   logic                r_done;
   logic                r_ready;

   logic                w_cnt_zero;
   logic [CNT_W-1:0]    w_cnt_dec;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_dec  = r_cnt - CNT_W'(1);

   // Every bus control line is a flop output so none of them can glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cs    <= 1'b1;
         r_read  <= 1'b1;
         r_write <= 1'b1;
         r_oe    <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_we    <= bus.we;
                  r_addr  <= bus.addr;
                  r_wdata <= bus.wdata;
                  r_cnt   <= SETUP_LOAD;
                  r_cs    <= 1'b0;
                  r_oe    <= bus.we;
                  r_ready <= 1'b0;
                  r_state <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (w_cnt_zero) begin
                  r_cnt   <= STROBE_LOAD;
                  r_read  <= r_we;
                  r_write <= ~r_we;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= w_cnt_dec;
               end
            end

            S_STROBE: begin
               if (w_cnt_zero) begin
                  // Sample on the edge that releases the strobe, while RD_n is still low.
                  if (!r_we) begin
                     r_rdata <= D;
                  end
                  r_read  <= 1'b1;
                  r_write <= 1'b1;
                  r_cnt   <= HOLD_LOAD;
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= w_cnt_dec;
               end
            end

            S_HOLD: begin
               if (w_cnt_zero) begin
                  r_cs    <= 1'b1;
                  r_oe    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_dec;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end

            default: begin
               r_cs    <= 1'b1;
               r_read  <= 1'b1;
               r_write <= 1'b1;
               r_oe    <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready = r_ready;
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;
   assign bus.cs    = r_cs;
   assign bus.read  = r_read;
   assign bus.write = r_write;
   assign bus.A_in  = r_addr;

   assign D = r_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed self-checking bench for ppi_bus_master: default timing, 1/1/1 timing and a 255-cycle strobe.
module tb_ppi_bus_master;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ppi_bus_master_if bus0 ();
   ppi_bus_master_if bus1 ();
   ppi_bus_master_if bus2 ();

   wire  [7:0] d0, d1, d2;
   logic       probe0, probe1, probe2;
   logic [7:0] tb_d0, tb_d1, tb_d2;

   // Peripheral model drives D only while it is selected and read; probe forces a drive to detect contention.
   assign d0 = (probe0 || (!bus0.cs && !bus0.read)) ? tb_d0 : 8'hzz;
   assign d1 = (probe1 || (!bus1.cs && !bus1.read)) ? tb_d1 : 8'hzz;
   assign d2 = (probe2 || (!bus2.cs && !bus2.read)) ? tb_d2 : 8'hzz;

   ppi_bus_master u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.master),
      .D     (d0)
   );

   ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.master),
      .D     (d1)
   );

   ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(255), .HOLD_CYC(1)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.master),
      .D     (d2)
   );

   task automatic test_reset();
      reset = 1'b0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 2'd0; bus0.wdata = 8'h00;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 2'd0; bus1.wdata = 8'h00;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 2'd0; bus2.wdata = 8'h00;
      probe0 = 1'b0; probe1 = 1'b0; probe2 = 1'b0;
      tb_d0 = 8'h00; tb_d1 = 8'h00; tb_d2 = 8'h00;
      #1 reset = 1'b1;
      #1;
      checks++; if (bus0.cs !== 1'b1) begin failures++; $display("FAIL rst_cs got=%b exp=1", bus0.cs); end
      checks++; if (bus0.read !== 1'b1) begin failures++; $display("FAIL rst_read got=%b exp=1", bus0.read); end
      checks++; if (bus0.write !== 1'b1) begin failures++; $display("FAIL rst_write got=%b exp=1", bus0.write); end
      checks++; if (bus0.A_in !== 2'd0) begin failures++; $display("FAIL rst_A_in got=%0d exp=0", bus0.A_in); end
      checks++; if (bus0.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", bus0.rdata); end
      checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus0.done); end
      checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus0.ready); end
      checks++; if (bus2.cs !== 1'b1 || bus2.ready !== 1'b1) begin failures++; $display("FAIL rst_dut2 cs=%b ready=%b exp=1/1", bus2.cs, bus2.ready); end
      probe0 = 1'b1;
      #1;
      checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL rst_D_released got=%h exp=00", d0); end
      probe0 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus0.ready !== 1'b1 || bus0.cs !== 1'b1) begin failures++; $display("FAIL rst_after ready=%b cs=%b exp=1/1", bus0.ready, bus0.cs); end
   endtask

   task automatic test_write();
      logic e_cs, e_wr, e_done, e_ready;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 2'd3; bus0.wdata = 8'h80;
      checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL wr_ready_accept got=%b exp=1", bus0.ready); end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin bus0.req = 1'b0; bus0.wdata = 8'h00; end
         e_cs    = !(k >= 1 && k <= 4);
         e_wr    = !(k == 2 || k == 3);
         e_done  = (k == 5);
         e_ready = (k == 6);
         checks++; if (bus0.cs !== e_cs) begin failures++; $display("FAIL wr_cs k=%0d got=%b exp=%b", k, bus0.cs, e_cs); end
         checks++; if (bus0.write !== e_wr) begin failures++; $display("FAIL wr_write k=%0d got=%b exp=%b", k, bus0.write, e_wr); end
         checks++; if (bus0.read !== 1'b1) begin failures++; $display("FAIL wr_read k=%0d got=%b exp=1", k, bus0.read); end
         checks++; if (bus0.A_in !== 2'd3) begin failures++; $display("FAIL wr_A_in k=%0d got=%0d exp=3", k, bus0.A_in); end
         checks++; if (bus0.done !== e_done) begin failures++; $display("FAIL wr_done k=%0d got=%b exp=%b", k, bus0.done, e_done); end
         checks++; if (bus0.ready !== e_ready) begin failures++; $display("FAIL wr_ready k=%0d got=%b exp=%b", k, bus0.ready, e_ready); end
         checks++; if (bus0.rdata !== 8'h00) begin failures++; $display("FAIL wr_rdata k=%0d got=%h exp=00", k, bus0.rdata); end
         if (k <= 4) begin
            checks++; if (d0 !== 8'h80) begin failures++; $display("FAIL wr_D k=%0d got=%h exp=80", k, d0); end
         end else begin
            tb_d0 = 8'h00; probe0 = 1'b1;
            #1;
            checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL wr_D_release k=%0d got=%h exp=00", k, d0); end
            probe0 = 1'b0;
         end
      end
   endtask

   task automatic test_read();
      logic e_cs, e_rd, e_done;
      tb_d0 = 8'h5A;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 2'd0; bus0.wdata = 8'hFF;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) bus0.req = 1'b0;
         e_cs   = !(k >= 1 && k <= 4);
         e_rd   = !(k == 2 || k == 3);
         e_done = (k == 5);
         checks++; if (bus0.cs !== e_cs) begin failures++; $display("FAIL rd_cs k=%0d got=%b exp=%b", k, bus0.cs, e_cs); end
         checks++; if (bus0.read !== e_rd) begin failures++; $display("FAIL rd_read k=%0d got=%b exp=%b", k, bus0.read, e_rd); end
         checks++; if (bus0.write !== 1'b1) begin failures++; $display("FAIL rd_write k=%0d got=%b exp=1", k, bus0.write); end
         checks++; if (bus0.done !== e_done) begin failures++; $display("FAIL rd_done k=%0d got=%b exp=%b", k, bus0.done, e_done); end
         if (k == 1) begin
            checks++; if (bus0.rdata !== 8'h00) begin failures++; $display("FAIL rd_rdata_before got=%h exp=00", bus0.rdata); end
         end
         if (k == 5) begin
            checks++; if (bus0.rdata !== 8'h5A) begin failures++; $display("FAIL rd_rdata got=%h exp=5a", bus0.rdata); end
         end
         if (k == 2 || k == 3) begin
            checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL rd_D_strobe k=%0d got=%h exp=5a", k, d0); end
         end else begin
            probe0 = 1'b1;
            #1;
            checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL rd_D_undriven k=%0d got=%h exp=5a", k, d0); end
            probe0 = 1'b0;
         end
      end
   endtask

   task automatic test_req_ignored();
      int done_cnt, a_bad, cs_bad;
      done_cnt = 0; a_bad = 0; cs_bad = 0;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 2'd1; bus0.wdata = 8'h3C;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) bus0.req = 1'b0;
         if (k == 2) begin bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 2'd2; bus0.wdata = 8'hFF; end
         if (k == 4) bus0.req = 1'b0;
         if (bus0.done === 1'b1) done_cnt++;
         if (bus0.A_in !== 2'd1) a_bad++;
         if (bus0.cs !== ((k >= 1 && k <= 4) ? 1'b0 : 1'b1)) cs_bad++;
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
      checks++; if (a_bad != 0) begin failures++; $display("FAIL ign_A_in_unstable cycles=%0d exp=0", a_bad); end
      checks++; if (cs_bad != 0) begin failures++; $display("FAIL ign_cs_pattern bad_cycles=%0d exp=0", cs_bad); end
      checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL ign_ready_end got=%b exp=1", bus0.ready); end
   endtask

   task automatic test_reset_mid();
      int done_cnt, not_ready;
      done_cnt = 0; not_ready = 0;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 2'd2; bus0.wdata = 8'h77;
      @(negedge clk);
      bus0.req = 1'b0;
      @(negedge clk);
      checks++; if (bus0.write !== 1'b0 || bus0.cs !== 1'b0) begin failures++; $display("FAIL mid_strobe write=%b cs=%b exp=0/0", bus0.write, bus0.cs); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus0.write !== 1'b1) begin failures++; $display("FAIL mid_write got=%b exp=1", bus0.write); end
      checks++; if (bus0.cs !== 1'b1) begin failures++; $display("FAIL mid_cs got=%b exp=1", bus0.cs); end
      checks++; if (bus0.rdata !== 8'h00) begin failures++; $display("FAIL mid_rdata got=%h exp=00", bus0.rdata); end
      tb_d0 = 8'h00; probe0 = 1'b1;
      #1;
      checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL mid_D_release got=%h exp=00", d0); end
      probe0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus0.done === 1'b1) done_cnt++;
         if (bus0.ready !== 1'b1) not_ready++;
      end
      checks++; if (done_cnt != 0) begin failures++; $display("FAIL mid_done_count got=%0d exp=0", done_cnt); end
      checks++; if (not_ready != 0) begin failures++; $display("FAIL mid_ready_low cycles=%0d exp=0", not_ready); end
   endtask

   task automatic test_back_to_back();
      logic       e_cs, e_rd, e_wr, e_done, e_ready;
      logic [1:0] e_a;
      tb_d1 = 8'hA5;
      @(negedge clk);
      bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 2'd0; bus1.wdata = 8'hFF;
      checks++; if (bus1.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_start got=%b exp=1", bus1.ready); end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1)  begin bus1.we = 1'b1; bus1.addr = 2'd2; bus1.wdata = 8'h55; end
         if (k == 6)  begin bus1.we = 1'b0; bus1.addr = 2'd1; bus1.wdata = 8'hFF; end
         if (k == 10) tb_d1 = 8'hC3;
         if (k == 11) bus1.req = 1'b0;
         e_cs    = !((k >= 1 && k <= 3) || (k >= 6 && k <= 8) || (k >= 11 && k <= 13));
         e_rd    = !(k == 2 || k == 12);
         e_wr    = !(k == 7);
         e_done  = (k == 4 || k == 9 || k == 14);
         e_ready = (k == 5 || k == 10 || k >= 15);
         e_a     = (k <= 5) ? 2'd0 : ((k <= 10) ? 2'd2 : 2'd1);
         checks++; if (!bus1.read && !bus1.write) begin failures++; $display("FAIL b2b_overlap k=%0d read=%b write=%b", k, bus1.read, bus1.write); end
         checks++; if (bus1.cs !== e_cs) begin failures++; $display("FAIL b2b_cs k=%0d got=%b exp=%b", k, bus1.cs, e_cs); end
         checks++; if (bus1.read !== e_rd) begin failures++; $display("FAIL b2b_read k=%0d got=%b exp=%b", k, bus1.read, e_rd); end
         checks++; if (bus1.write !== e_wr) begin failures++; $display("FAIL b2b_write k=%0d got=%b exp=%b", k, bus1.write, e_wr); end
         checks++; if (bus1.done !== e_done) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus1.done, e_done); end
         checks++; if (bus1.ready !== e_ready) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus1.ready, e_ready); end
         checks++; if (bus1.A_in !== e_a) begin failures++; $display("FAIL b2b_A_in k=%0d got=%0d exp=%0d", k, bus1.A_in, e_a); end
         if (k == 7) begin
            checks++; if (d1 !== 8'h55) begin failures++; $display("FAIL b2b_D_write got=%h exp=55", d1); end
         end
         if (k == 4 || k == 9) begin
            checks++; if (bus1.rdata !== 8'hA5) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h exp=a5", k, bus1.rdata); end
         end
         if (k == 14) begin
            checks++; if (bus1.rdata !== 8'hC3) begin failures++; $display("FAIL b2b_rdata2 got=%h exp=c3", bus1.rdata); end
         end
      end
   endtask

   task automatic test_long_strobe();
      int         rd_low, first_low, done_k, cs_low;
      logic [7:0] rd_at_done;
      rd_low = 0; first_low = -1; done_k = -1; cs_low = 0; rd_at_done = 8'h00;
      tb_d2 = 8'h11;
      @(negedge clk);
      bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 2'd2; bus2.wdata = 8'hFF;
      for (int k = 1; k <= 265; k++) begin
         @(negedge clk);
         if (k == 1) bus2.req = 1'b0;
         if (k == 201) tb_d2 = 8'h22;
         if (bus2.read === 1'b0) begin
            rd_low++;
            if (first_low < 0) first_low = k;
         end
         if (bus2.cs === 1'b0) cs_low++;
         if (bus2.done === 1'b1 && done_k < 0) begin
            done_k = k;
            rd_at_done = bus2.rdata;
         end
      end
      checks++; if (rd_low != 255) begin failures++; $display("FAIL long_read_low got=%0d exp=255", rd_low); end
      checks++; if (first_low != 2) begin failures++; $display("FAIL long_first_strobe got=%0d exp=2", first_low); end
      checks++; if (cs_low != 257) begin failures++; $display("FAIL long_cs_low got=%0d exp=257", cs_low); end
      checks++; if (done_k != 258) begin failures++; $display("FAIL long_done_cycle got=%0d exp=258", done_k); end
      checks++; if (rd_at_done !== 8'h22) begin failures++; $display("FAIL long_rdata got=%h exp=22", rd_at_done); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_req_ignored();
      test_reset_mid();
      test_back_to_back();
      test_long_strobe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
